// File: rtl/breakout_pkg.sv
// Shared constants for the breakout ball engine: screen walls, paddle faces,
// serve point, ball geometry, state and direction encodings.
package breakout_pkg;

   localparam logic [10:0] BALL_SIZE = 11'd8;
   localparam logic [10:0] BALL_V    = 11'd2;
   localparam logic [10:0] WALL_T    = 11'd0;
   localparam logic [10:0] WALL_B    = 11'd599;
   localparam logic [10:0] WALL_L    = 11'd0;
   localparam logic [10:0] X_MAX     = 11'd2047;
   localparam logic [10:0] MISS_X    = 11'd799;
   localparam logic [10:0] PAD_X_L   = 11'd776;
   localparam logic [10:0] PAD_X_R   = 11'd783;
   localparam logic [10:0] SERVE_X   = 11'd760;
   localparam logic [10:0] SERVE_Y   = 11'd296;

   localparam logic [1:0] LIVES_INIT = 2'd3;

   localparam logic [1:0] SERVE = 2'd0;
   localparam logic [1:0] PLAY  = 2'd1;
   localparam logic [1:0] MISS  = 2'd2;
   localparam logic [1:0] OVER  = 2'd3;

   // negative = left / up, positive = right / down
   localparam logic DIR_NEG = 1'b0;
   localparam logic DIR_POS = 1'b1;

   function automatic logic [10:0] far_edge(input logic [10:0] near);
      return near + BALL_SIZE - 11'd1;
   endfunction

endpackage

// File: rtl/breakout_ball_ctrl_if.sv
// Column hit bus: ball edges out to every block column, ORed
// redirect pulses back to the ball controller.
interface breakout_ball_ctrl_if;

   logic        moveU;
   logic        moveD;
   logic        moveL;
   logic        moveR;
   logic [10:0] ball_x_l;
   logic [10:0] ball_x_r;
   logic [10:0] ball_y_t;
   logic [10:0] ball_y_b;

   modport master (
      output ball_x_l, ball_x_r, ball_y_t, ball_y_b,
      input  moveU, moveD, moveL, moveR
   );

   modport slave (
      input  ball_x_l, ball_x_r, ball_y_t, ball_y_b,
      output moveU, moveD, moveL, moveR
   );

endinterface

// File: rtl/breakout_ball_axis.sv
// One motion axis: direction register plus clamped position and far edge.
// Used once for x and once for y.
module breakout_ball_axis
   import breakout_pkg::*;
#(
   parameter logic [10:0] INIT = 11'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        tick,
   input  logic        dir_set,
   input  logic        dir_clr,
   input  logic        dir_rev,
   input  logic [10:0] step,
   input  logic [10:0] lo,
   input  logic [10:0] hi,
   output logic [10:0] pos,
   output logic [10:0] pos_hi,
   output logic        dir
);

   logic        dir_n;
   logic [10:0] pos_n;

   always_comb begin
      dir_n = dir;
      if (dir_set)
         dir_n = DIR_POS;
      else if (dir_clr)
         dir_n = DIR_NEG;
      else if (dir_rev)
         dir_n = ~dir;

      // saturate at the limits instead of wrapping through 0 / 2047
      if (dir_n == DIR_NEG)
         pos_n = (pos < lo + step) ? lo : pos - step;
      else
         pos_n = (pos_hi > hi - step) ?
                 hi - (BALL_SIZE - 11'd1) : pos + step;
   end

   always_ff @(posedge clk) begin
      if (reset || load) begin
         pos    <= INIT;
         pos_hi <= far_edge(INIT);
         dir    <= DIR_NEG;
      end else if (tick) begin
         pos    <= pos_n;
         pos_hi <= far_edge(pos_n);
         dir    <= dir_n;
      end
   end

endmodule

// File: rtl/breakout_ball_ctrl.sv
// Ball motion, hit latching and serve/play/miss/over flow.
// Optional BALL_SPEEDUP_EN: step grows with the number of block hits.
module breakout_ball_ctrl
   import breakout_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        refresh_tick,
   input  logic        launch,
   input  logic [10:0] pix_x,
   input  logic [10:0] pix_y,
   input  logic [10:0] paddle_y_t,
   input  logic [10:0] paddle_y_b,
   breakout_ball_ctrl_if.master bus,
   output logic        ball_ON,
   output logic [1:0]  lives,
   output logic        miss,
   output logic        game_over
);

   logic [1:0]  state, state_n;
   logic        hit_u, hit_d, hit_l, hit_r;
   logic        eff_u, eff_d, eff_l, eff_r;
   logic        serve_go, play_tick, miss_hit, pad_hit, move;
   logic        x_set, x_clr, x_rev, y_set, y_clr, y_rev;
   logic        dir_x, dir_y;
   logic [10:0] step;

   assign eff_u = hit_u | bus.moveU;
   assign eff_d = hit_d | bus.moveD;
   assign eff_l = hit_l | bus.moveL;
   assign eff_r = hit_r | bus.moveR;

   assign serve_go  = refresh_tick && state == SERVE && launch;
   assign play_tick = refresh_tick && state == PLAY;
   assign miss_hit  = bus.ball_x_r >= MISS_X;
   assign pad_hit   = bus.ball_x_r >= PAD_X_L &&
                      bus.ball_x_r <= PAD_X_R &&
                      bus.ball_y_b >= paddle_y_t &&
                      bus.ball_y_t <= paddle_y_b;
   assign move      = serve_go || (play_tick && !miss_hit);

   always_comb begin
      x_set = 1'b0;
      x_clr = 1'b0;
      x_rev = 1'b0;
      y_set = 1'b0;
      y_clr = 1'b0;
      y_rev = 1'b0;
      if (serve_go) begin
         x_clr = 1'b1;
         y_clr = 1'b1;
      end else if (play_tick) begin
         if (pad_hit)
            x_clr = 1'b1;
         else if (bus.ball_x_l <= WALL_L)
            x_set = 1'b1;
         else if (eff_l && eff_r)
            x_rev = 1'b1;
         else if (eff_r)
            x_set = dir_x == DIR_NEG;
         else if (eff_l)
            x_clr = dir_x == DIR_POS;

         if (bus.ball_y_t <= WALL_T)
            y_set = 1'b1;
         else if (bus.ball_y_b >= WALL_B)
            y_clr = 1'b1;
         else if (eff_u && eff_d)
            y_rev = 1'b1;
         else if (eff_u)
            y_clr = dir_y == DIR_POS;
         else if (eff_d)
            y_set = dir_y == DIR_NEG;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         SERVE: if (serve_go) state_n = PLAY;
         PLAY:  if (play_tick && miss_hit) state_n = MISS;
         MISS:  state_n = (lives == 2'd1) ? OVER : SERVE;
         OVER:  state_n = OVER;
         default: state_n = SERVE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SERVE;
         lives <= LIVES_INIT;
      end else begin
         state <= state_n;
         if (state == MISS)
            lives <= lives - 2'd1;
      end
   end

   // the tick cycle consumes the latches, including same-cycle pulses
   always_ff @(posedge clk) begin
      if (reset || state != PLAY || refresh_tick) begin
         hit_u <= 1'b0;
         hit_d <= 1'b0;
         hit_l <= 1'b0;
         hit_r <= 1'b0;
      end else begin
         hit_u <= eff_u;
         hit_d <= eff_d;
         hit_l <= eff_l;
         hit_r <= eff_r;
      end
   end

`ifdef BALL_SPEEDUP_EN
   logic [5:0] hit_cnt;
   logic       any_q, counted, rise;

   assign rise = (bus.moveU | bus.moveD | bus.moveL | bus.moveR) & ~any_q;

   always_ff @(posedge clk) begin
      if (reset || state == MISS) begin
         hit_cnt <= 6'd0;
         any_q   <= 1'b0;
         counted <= 1'b0;
      end else begin
         any_q   <= bus.moveU | bus.moveD | bus.moveL | bus.moveR;
         counted <= refresh_tick ? 1'b0 : (counted | rise);
         if (rise && !counted && hit_cnt != 6'd63)
            hit_cnt <= hit_cnt + 6'd1;
      end
   end

   always_comb begin
      step = BALL_V + 11'(hit_cnt[5:3]);
      if (hit_cnt[5:3] > 3'd3)
         step = BALL_V + 11'd3;
   end
`else
   assign step = BALL_V;
`endif

   breakout_ball_axis #(.INIT(SERVE_X)) u_x (
      .clk     (clk),
      .reset   (reset),
      .load    (state == MISS),
      .tick    (move),
      .dir_set (x_set),
      .dir_clr (x_clr),
      .dir_rev (x_rev),
      .step    (step),
      .lo      (WALL_L),
      .hi      (X_MAX),
      .pos     (bus.ball_x_l),
      .pos_hi  (bus.ball_x_r),
      .dir     (dir_x)
   );

   breakout_ball_axis #(.INIT(SERVE_Y)) u_y (
      .clk     (clk),
      .reset   (reset),
      .load    (state == MISS),
      .tick    (move),
      .dir_set (y_set),
      .dir_clr (y_clr),
      .dir_rev (y_rev),
      .step    (step),
      .lo      (WALL_T),
      .hi      (WALL_B),
      .pos     (bus.ball_y_t),
      .pos_hi  (bus.ball_y_b),
      .dir     (dir_y)
   );

   assign miss      = state == MISS;
   assign game_over = state == OVER;
   assign ball_ON   = pix_x >= bus.ball_x_l && pix_x <= bus.ball_x_r &&
                      pix_y >= bus.ball_y_t && pix_y <= bus.ball_y_b;

endmodule

// File: tb/tb_breakout_ball_ctrl.sv
// Random play against an integer model of the ball rules, plus directed
// serve, redirect and game-over sequences.
module tb_breakout_ball_ctrl;

   logic        clk = 1'b0;
   logic        reset, refresh_tick, launch;
   logic [10:0] pix_x, pix_y, paddle_y_t, paddle_y_b;
   logic        ball_ON, miss, game_over;
   logic [1:0]  lives;

   breakout_ball_ctrl_if bus ();

   breakout_ball_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .refresh_tick (refresh_tick),
      .launch       (launch),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .paddle_y_t   (paddle_y_t),
      .paddle_y_b   (paddle_y_b),
      .bus          (bus.master),
      .ball_ON      (ball_ON),
      .lives        (lives),
      .miss         (miss),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   typedef enum int {M_SERVE, M_PLAY, M_MISS, M_OVER} mstate_t;

   mstate_t mst;
   int      mx, my, mdx, mdy, mlives;
   bit      hu, hd, hl, hr;
   bit      track;
   int      n_tests = 0;
   int      n_fail  = 0;
   int      cyc     = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0d, expected %0d",
                  tag, cyc, got, exp);
      end
   endtask

   task automatic do_move();
      if (mdx < 0) mx = (mx < 2) ? 0 : mx - 2;
      else         mx = mx + 2;
      if (mdy < 0) my = (my < 2) ? 0 : my - 2;
      else         my = (my + 7 + 2 > 599) ? 592 : my + 2;
   endtask

   task automatic model_reset();
      mst = M_SERVE; mx = 760; my = 296; mdx = -1; mdy = -1;
      mlives = 3; hu = 0; hd = 0; hl = 0; hr = 0;
   endtask

   task automatic model_step();
      bit eu, ed, el, er;
      int pt, pb;
      eu = hu | bus.moveU; ed = hd | bus.moveD;
      el = hl | bus.moveL; er = hr | bus.moveR;
      pt = int'(paddle_y_t); pb = int'(paddle_y_b);
      if (reset) begin
         model_reset();
         return;
      end
      case (mst)
         M_SERVE: if (refresh_tick && launch) begin
            mdx = -1; mdy = -1; do_move(); mst = M_PLAY;
         end
         M_PLAY: if (refresh_tick) begin
            hu = 0; hd = 0; hl = 0; hr = 0;
            if (mx + 7 >= 799) mst = M_MISS;
            else begin
               if (mx + 7 >= 776 && mx + 7 <= 783 && my + 7 >= pt && my <= pb)
                  mdx = -1;
               else if (mx <= 0) mdx = 1;
               else if (el && er) mdx = -mdx;
               else if (er) mdx = 1;
               else if (el) mdx = -1;
               if (my <= 0) mdy = 1;
               else if (my + 7 >= 599) mdy = -1;
               else if (eu && ed) mdy = -mdy;
               else if (eu) mdy = -1;
               else if (ed) mdy = 1;
               do_move();
            end
         end else begin
            hu = eu; hd = ed; hl = el; hr = er;
         end
         M_MISS: begin
            mlives--;
            mst = (mlives == 0) ? M_OVER : M_SERVE;
            mx = 760; my = 296; mdx = -1; mdy = -1;
         end
         default: ;
      endcase
   endtask

   task automatic compare_all();
      bit on;
      on = int'(pix_x) >= mx && int'(pix_x) <= mx + 7 &&
           int'(pix_y) >= my && int'(pix_y) <= my + 7;
      check("x_l", int'(bus.ball_x_l), mx);
      check("x_r", int'(bus.ball_x_r), mx + 7);
      check("y_t", int'(bus.ball_y_t), my);
      check("y_b", int'(bus.ball_y_b), my + 7);
      check("lives", int'(lives), mlives);
      check("miss", int'(miss), int'(mst == M_MISS));
      check("game_over", int'(game_over), int'(mst == M_OVER));
      check("ball_ON", int'(ball_ON), int'(on));
   endtask

   task automatic step_cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      cyc++;
      @(negedge clk);
   endtask

   task automatic set_paddle();
      int pt, pb;
      if (track) begin
         pt = (my > 20) ? my - 20 : 0;
         pb = my + 30;
      end else if (my > 100) begin
         pt = 0; pb = 50;
      end else begin
         pt = 500; pb = 599;
      end
      paddle_y_t = 11'(pt);
      paddle_y_b = 11'(pb);
   endtask

   task automatic set_pix();
      int px, py;
      px = mx + int'($urandom_range(0, 11)) - 2;
      py = my + int'($urandom_range(0, 11)) - 2;
      pix_x = 11'((px < 0) ? 0 : px);
      pix_y = 11'((py < 0) ? 0 : py);
   endtask

   task automatic clear_moves();
      bus.moveU = 0; bus.moveD = 0; bus.moveL = 0; bus.moveR = 0;
   endtask

   initial begin
      int over_cnt;
      int guard;
      reset = 1; refresh_tick = 0; launch = 0;
      pix_x = 0; pix_y = 0; paddle_y_t = 0; paddle_y_b = 50;
      clear_moves();
      track = 0;
      model_reset();
      @(negedge clk);
      step_cycle();
      step_cycle();
      reset = 0;
      check("rst_lives", int'(lives), 3);
      check("rst_over", int'(game_over), 0);

      // serve: one tick moves the ball up-left by 2
      launch = 1; refresh_tick = 1;
      step_cycle();
      launch = 0; refresh_tick = 0;
      check("serve_x_l", int'(bus.ball_x_l), 758);
      check("serve_y_t", int'(bus.ball_y_t), 294);
      check("serve_x_r", int'(bus.ball_x_r), 765);
      check("serve_y_b", int'(bus.ball_y_b), 301);

      // mid-interval moveR pulse turns the ball right on the next tick
      bus.moveR = 1; step_cycle();
      bus.moveR = 0; step_cycle();
      refresh_tick = 1; step_cycle(); refresh_tick = 0;
      check("moveR_x_l", int'(bus.ball_x_l), 760);
      step_cycle();
      refresh_tick = 1; step_cycle(); refresh_tick = 0;
      check("hit_r_clear", int'(bus.ball_x_l), 762);

      // simultaneous L and R while moving right reverses to left
      bus.moveL = 1; bus.moveR = 1; step_cycle();
      clear_moves();
      refresh_tick = 1; step_cycle(); refresh_tick = 0;
      check("both_rev_x_l", int'(bus.ball_x_l), 760);

      // randomized play
      over_cnt = 0;
      for (int c = 0; c < 40000; c++) begin
         refresh_tick = (c % 3 == 0);
         launch = 1'($urandom_range(0, 1));
         bus.moveU = ($urandom_range(0, 31) == 0);
         bus.moveD = ($urandom_range(0, 31) == 0);
         bus.moveL = ($urandom_range(0, 31) == 0);
         bus.moveR = ($urandom_range(0, 31) == 0);
         over_cnt = (mst == M_OVER) ? over_cnt + 1 : 0;
         reset = ($urandom_range(0, 9999) == 0) || over_cnt > 40;
         if (mst == M_SERVE) track = ($urandom_range(0, 2) != 0);
         set_paddle();
         set_pix();
         step_cycle();
      end
      reset = 0;
      clear_moves();

      // three misses in a row end the game
      reset = 1; step_cycle(); reset = 0;
      track = 0; launch = 1;
      guard = 0;
      while (mst != M_OVER && guard < 20000) begin
         refresh_tick = (guard % 2 == 0);
         set_paddle();
         set_pix();
         step_cycle();
         guard++;
      end
      check("over_reached", int'(game_over), 1);
      check("over_lives", int'(lives), 0);
      for (int c = 0; c < 20; c++) begin
         refresh_tick = (c % 2 == 0);
         set_pix();
         step_cycle();
      end
      check("over_frozen", int'(bus.ball_x_l), 760);
      refresh_tick = 0; launch = 0;
      reset = 1; step_cycle(); reset = 0;
      check("rst_after_over", int'(lives), 3);
      check("rst_after_over_go", int'(game_over), 0);
      step_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/breakout_ball_ctrl.md
Name: breakout_ball_ctrl

Overview:
Ball motion engine and the consumer end of the block-column hit interface. It takes the ORed moveU/moveD/moveL/moveR redirect pulses from all breakout_blocks_Cn columns, plus wall and paddle collisions. From these it updates ball direction and position once per frame tick and drives ball_x_l/ball_x_r/ball_y_t/ball_y_b back to every column and to the pixel mux. It also owns the serve/play/miss/game-over flow and the lives count.

Parameters:
BALL_SIZE, 8, ball edge length in pixels
BALL_V, 2, pixels moved per axis per refresh_tick
WALL_T, 0, top wall y
WALL_B, 599, bottom wall y
WALL_L, 0, left wall x
MISS_X, 799, a ball_x_r at or beyond this x is a miss
PAD_X_L, 776, paddle left face x
PAD_X_R, 783, paddle right face x
SERVE_X, 760, ball_x_l at serve
SERVE_Y, 296, ball_y_t at serve
LIVES_INIT, 3, lives at reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
refresh_tick  in  1  one-cycle pulse per frame (60 Hz)
launch  in  1  level; serves the ball in SERVE
pix_x  in  11  current pixel x
pix_y  in  11  current pixel y
paddle_y_t  in  11  paddle top y
paddle_y_b  in  11  paddle bottom y
moveU  in  1  ORed column hit: go up
moveD  in  1  ORed column hit: go down
moveL  in  1  ORed column hit: go left
moveR  in  1  ORed column hit: go right
ball_x_l  out  11  ball left x
ball_x_r  out  11  ball right x, equal to ball_x_l+BALL_SIZE-1
ball_y_t  out  11  ball top y
ball_y_b  out  11  ball bottom y, equal to ball_y_t+BALL_SIZE-1
ball_ON  out  1  pixel is inside the ball; combinational from pix_x/pix_y and the registered coordinates
lives  out  2  remaining lives
miss  out  1  one-cycle pulse on a miss
game_over  out  1  high in OVER

Behaviour:
- Reset: state=SERVE; ball_x_l=SERVE_X; ball_y_t=SERVE_Y; dir_x=left; dir_y=up; lives=LIVES_INIT; miss=0; game_over=0; hit latches cleared. Reset mid-play gives the same result in the next cycle.
- States:
  - SERVE: position is held at serve. launch=1 on a refresh_tick moves to PLAY with dir_x=left and dir_y=up.
  - PLAY: motion and collisions are active (see below).
  - MISS: one cycle. lives decrements, miss=1. If lives was 1, next state is OVER, otherwise SERVE.
  - OVER: position is frozen and game_over=1. Only reset exits OVER.
- Hit latching: moveX inputs arrive 1 cycle after a coordinate change and last 1 cycle or more. Each is OR-latched into hit_u/hit_d/hit_l/hit_r between ticks. The latches clear on the cycle that consumes them (the refresh_tick). The latches do not capture in SERVE or OVER.
- Update on refresh_tick in PLAY. Direction is resolved first, then position:
  - x direction, first match wins:
    1. ball_x_r >= MISS_X: go to MISS.
    2. Paddle: ball_x_r in [PAD_X_L, PAD_X_R] and the y ranges overlap (ball_y_b >= paddle_y_t and ball_y_t <= paddle_y_b): dir_x=left.
    3. ball_x_l <= WALL_L: dir_x=right.
    4. hit_l and hit_r both set: reverse dir_x. hit_r only: dir_x=right. hit_l only: dir_x=left.
  - y direction, first match wins:
    1. ball_y_t <= WALL_T: dir_y=down.
    2. ball_y_b >= WALL_B: dir_y=up.
    3. hit_u and hit_d both set: reverse dir_y. hit_u only: dir_y=up. hit_d only: dir_y=down.
  - Position uses the new direction: step ±BALL_V on each axis.
  - Clamp, no wrap: moving left with ball_x_l < WALL_L+BALL_V sets ball_x_l=WALL_L. The same rule applies to ball_y_t against WALL_T, and to ball_y_b against WALL_B.
- Outputs are registered. Coordinate latency is 1 cycle after refresh_tick.
- Arithmetic is 11-bit unsigned throughout. ball_x_r and ball_y_b are derived registers updated in the same cycle as ball_x_l and ball_y_t.
- refresh_tick and moveX in the same cycle: that moveX is included in the consumed decision.

Optional Feature:
BALL_SPEEDUP_EN
- Defined:
  - A 6-bit counter counts rising edges of (moveU|moveD|moveL|moveR), at most one per tick interval.
  - Step = BALL_V + (count>>3), saturating at BALL_V+3.
  - Step resets to BALL_V on reset and on MISS.
- Undefined: step is the constant BALL_V and the counter is absent.

Decomposition:
- Package breakout_pkg:
  - screen and wall constants
  - BALL_SIZE
  - ball state encoding: SERVE=2'd0, PLAY=2'd1, MISS=2'd2, OVER=2'd3
  - direction encodings
- Sub-module breakout_ball_axis, instantiated for x and for y:
  - inputs: tick, dir_set, dir_clr, dir_rev, step, lo/hi limits
  - output: position and direction registers with the clamp logic

Test Plan:
- Reset, then launch=1 and 1 tick -> state PLAY; ball_x_l=758, ball_y_t=294, ball_x_r=765, ball_y_b=301.
- Ball moving left, pulse moveR for 1 cycle mid-interval -> on the next tick dir_x=right and ball_x_l increases by 2; hit_r cleared.
- moveL and moveR together while dir_x=right -> on the next tick dir_x=left. Separately, moveU with ball_y_t=0 in the same tick -> top wall wins and dir_y=down.
- Ball at ball_y_t=1, dir up -> ball_y_t clamps to 0 (no wrap to 2047); the next tick gives dir_y=down and ball_y_t=2.
- Paddle at y 280..340, ball_x_r=777, ball_y_t=300, dir right -> dir_x=left. Same case with paddle at y 0..50 -> ball reaches x_r>=799, miss pulses, lives goes 3→2, state SERVE at (760,296).
- Three consecutive misses -> lives=0, game_over=1, ball frozen; launch ignored; reset restores lives=3 and SERVE.
